// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size and MEM-stage FSM state encodings shared by the data-memory access path.
package mips_mem_pkg;
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
endpackage

// File: rtl/mem_stage_access_unit_lane_align.sv
// mem_lane_align: big-endian byte-lane enables, store replication and sign-extended load extraction.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   logic        is_b;
   logic        is_h;
   logic [31:0] b_sh;
   logic [15:0] h_lane;
   always_comb begin
      is_b    = size_i == SZ_BYTE;
      is_h    = size_i == SZ_HALF;
      // lane 0 is the most significant byte, so the shift is (3 - off) bytes
      b_sh    = rdata_i >> {~off_i, 3'b000};
      h_lane  = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
      be_o    = is_b ? (4'b1000 >> off_i) : is_h ? (off_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
      wdata_o = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
      rdata_o = is_b ? {{24{b_sh[7]}}, b_sh[7:0]} : is_h ? {{16{h_lane[15]}}, h_lane} : rdata_i;
   end
endmodule

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM-stage req/ack data-memory access with stall, timeout and load extraction.
module mem_stage_access_unit
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [1:0]  MuxLoad_in,
   input  logic [31:0] Addr_in,
   input  logic [31:0] StoreData_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        Stall_out,
   output logic [31:0] LoadData_out,
   output logic        LoadValid_out,
   output logic        Misaligned_out,
   output logic        BusError_out
);
   state_t            state_q;
   logic [TO_W-1:0]   cnt_q;
   logic [1:0]        sz_q;
   logic [1:0]        off_q;
   logic              req_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       ld_q;
   logic              lv_q;
   logic              mis_q;
   logic              berr_q;
   logic              access;
   logic              conflict;
   logic              misal;
   logic              issue;
   logic [1:0]        sz_sel;
   logic [1:0]        off_sel;
   logic [3:0]        be_w;
   logic [31:0]       wdata_w;
   logic [31:0]       rdata_w;
   always_comb begin
      access    = MemRead_in | MemWrite_in;
      conflict  = MemRead_in & MemWrite_in;
      misal     = MuxLoad_in == SZ_HALF ? Addr_in[0] : MuxLoad_in == SZ_BYTE ? 1'b0 : |Addr_in[1:0];
      issue     = state_q == S_IDLE && access && !conflict && !misal;
      Stall_out = issue || state_q == S_ACCESS;
      // while a transaction is in flight the aligner extracts load data with the latched size/offset
      sz_sel    = state_q == S_IDLE ? MuxLoad_in : sz_q;
      off_sel   = state_q == S_IDLE ? Addr_in[1:0] : off_q;
   end
   mem_lane_align u_align (
      .size_i  (sz_sel),
      .off_i   (off_sel),
      .wdata_i (StoreData_in),
      .rdata_i (mem_rdata),
      .be_o    (be_w),
      .wdata_o (wdata_w),
      .rdata_o (rdata_w)
   );
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sz_q    <= '0;
         off_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         lv_q    <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         lv_q   <= 1'b0;
         mis_q  <= 1'b0;
         berr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               berr_q <= conflict;
               mis_q  <= access && !conflict && misal;
               if (issue) begin
                  req_q   <= 1'b1;
                  we_q    <= MemWrite_in;
                  addr_q  <= {Addr_in[31:2], 2'b00};
                  be_q    <= be_w;
                  wdata_q <= wdata_w;
                  sz_q    <= MuxLoad_in;
                  off_q   <= Addr_in[1:0];
                  cnt_q   <= '0;
                  state_q <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_DONE;
                  if (!we_q) begin
                     ld_q <= rdata_w;
                     lv_q <= 1'b1;
                  end
               end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                  req_q   <= 1'b0;
                  berr_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign mem_req        = req_q;
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_be         = be_q;
   assign mem_wdata      = wdata_q;
   assign LoadData_out   = ld_q;
   assign LoadValid_out  = lv_q;
   assign Misaligned_out = mis_q;
   assign BusError_out   = berr_q;
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb_mem_stage_access_unit: transaction-level model of the MEM access unit, checked every cycle plus directed literals.
module tb_mem_stage_access_unit;
   localparam int TIMEOUT = 16;
   logic        Clk = 1'b0;
   logic        Rst;
   logic        MemRead_in, MemWrite_in;
   logic [1:0]  MuxLoad_in;
   logic [31:0] Addr_in, StoreData_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        Stall_out, LoadValid_out, Misaligned_out, BusError_out;
   logic [31:0] LoadData_out;

   mem_stage_access_unit #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .Clk(Clk), .Rst(Rst), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MuxLoad_in(MuxLoad_in), .Addr_in(Addr_in), .StoreData_in(StoreData_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .Stall_out(Stall_out), .LoadData_out(LoadData_out), .LoadValid_out(LoadValid_out),
      .Misaligned_out(Misaligned_out), .BusError_out(BusError_out)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   bit chk_on = 1'b0;
   logic        exp_stall, exp_req, exp_we, exp_lv, exp_mis, exp_berr;
   logic [31:0] exp_addr, exp_wdata, exp_ld;
   logic [3:0]  exp_be;
   logic        nxt_req, nxt_we, nxt_lv, nxt_mis, nxt_berr;
   logic [31:0] nxt_addr, nxt_wdata, nxt_ld;
   logic [3:0]  nxt_be;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;

   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'b10) return 4'b1000 >> off;
      if (sz == 2'b01) return off[1] ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'b10) return {4{d[7:0]}};
      if (sz == 2'b01) return {2{d[15:0]}};
      return d;
   endfunction

   function automatic logic [31:0] ext_of(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] d);
      logic [31:0] s;
      if (sz == 2'b10) begin
         s = d >> (8 * (3 - int'(off)));
         return {{24{s[7]}}, s[7:0]};
      end
      if (sz == 2'b01) begin
         s = d >> (off[1] ? 0 : 16);
         return {{16{s[15]}}, s[15:0]};
      end
      return d;
   endfunction

   task automatic model_clear();
      nxt_req = 0; nxt_we = 0; nxt_addr = 0; nxt_be = 0; nxt_wdata = 0;
      nxt_ld = 0; nxt_lv = 0; nxt_mis = 0; nxt_berr = 0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      exp_req = nxt_req; exp_we = nxt_we; exp_addr = nxt_addr; exp_be = nxt_be;
      exp_wdata = nxt_wdata; exp_ld = nxt_ld; exp_lv = nxt_lv; exp_mis = nxt_mis; exp_berr = nxt_berr;
      nxt_lv = 0; nxt_mis = 0; nxt_berr = 0;
      MemRead_in = 0; MemWrite_in = 0; mem_ack = 0; Rst = 0; exp_stall = 0;
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] sd);
      MemRead_in = rd; MemWrite_in = wr; MuxLoad_in = sz; Addr_in = a; StoreData_in = sd;
   endtask

   // lat = ACCESS cycle in which mem_ack arrives; 0 means never
   task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rdat, input int lat);
      bit al;
      al = (sz == 2'b01) ? (a % 2 == 0) : (sz == 2'b10) ? 1'b1 : (a % 4 == 0);
      step();
      drive(rd, wr, sz, a, sd);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (rd && wr) begin
         nxt_berr = 1;
         return;
      end
      if (!(rd || wr)) return;
      if (!al) begin
         nxt_mis = 1;
         return;
      end
      exp_stall = 1; nxt_req = 1; nxt_we = wr; nxt_addr = {a[31:2], 2'b00};
      nxt_be = be_of(sz, a[1:0]); nxt_wdata = rep_of(sz, sd);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
         drive(rd, wr, sz, a, sd);
         exp_stall = 1;
         if (k == 1) begin
            cap_we = mem_we; cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
         end
         if (k == lat) begin
            mem_ack = 1; mem_rdata = rdat; nxt_req = 0;
            if (rd) begin
               nxt_lv = 1;
               nxt_ld = ext_of(sz, a[1:0], rdat);
            end
            break;
         end
         mem_rdata = $urandom;
         if (k == TIMEOUT) begin
            nxt_req = 0;
            nxt_berr = 1;
         end
      end
      step();
      drive(rd, wr, sz, a, sd);
      mem_ack = 1'($urandom_range(0, 1));
   endtask

   always @(negedge Clk) begin
      if (chk_on) begin
         if (Stall_out) stall_cnt++;
         cmp("stall", 32'(Stall_out), 32'(exp_stall));
         cmp("req", 32'(mem_req), 32'(exp_req));
         cmp("lvalid", 32'(LoadValid_out), 32'(exp_lv));
         cmp("misal", 32'(Misaligned_out), 32'(exp_mis));
         cmp("buserr", 32'(BusError_out), 32'(exp_berr));
         cmp("ldata", LoadData_out, exp_ld);
         if (exp_req) begin
            cmp("we", 32'(mem_we), 32'(exp_we));
            cmp("addr", mem_addr, exp_addr);
            cmp("be", 32'(mem_be), 32'(exp_be));
            cmp("wdata", mem_wdata, exp_wdata);
         end
      end
   end

   initial begin
      Rst = 1; MemRead_in = 0; MemWrite_in = 0; MuxLoad_in = 0; Addr_in = 0; StoreData_in = 0;
      mem_ack = 0; mem_rdata = 0;
      model_clear();
      repeat (2) @(posedge Clk);
      step();
      chk_on = 1;
      stall_cnt = 0;
      op(1, 0, 2'b00, 32'h100, 0, 32'hDEADBEEF, 3);
      cmp("lw_stall_cycles", stall_cnt, 4);
      cmp("lw_be", 32'(cap_be), 32'hF);
      cmp("lw_lvalid", 32'(LoadValid_out), 1);
      cmp("lw_data", LoadData_out, 32'hDEADBEEF);
      op(1, 0, 2'b10, 32'h103, 0, 32'h11223380, 1);
      cmp("lb_addr", cap_addr, 32'h100);
      cmp("lb_be", 32'(cap_be), 32'h1);
      cmp("lb_data", LoadData_out, 32'hFFFFFF80);
      op(0, 1, 2'b01, 32'h202, 32'h0000ABCD, 0, 2);
      cmp("sh_we", 32'(cap_we), 1);
      cmp("sh_be", 32'(cap_be), 32'h3);
      cmp("sh_wdata", cap_wdata, 32'hABCDABCD);
      cmp("sh_no_lvalid", 32'(LoadValid_out), 0);
      op(1, 0, 2'b00, 32'h101, 0, 0, 1);
      step();
      cmp("mis_pulse", 32'(Misaligned_out), 1);
      cmp("mis_no_req", 32'(mem_req), 0);
      op(1, 1, 2'b00, 32'h200, 0, 0, 1);
      step();
      cmp("conflict_berr", 32'(BusError_out), 1);
      stall_cnt = 0;
      op(1, 0, 2'b00, 32'h300, 0, 0, 0);
      cmp("to_stall_cycles", stall_cnt, TIMEOUT + 1);
      cmp("to_berr", 32'(BusError_out), 1);
      cmp("to_no_lvalid", 32'(LoadValid_out), 0);
      cmp("to_req_drop", 32'(mem_req), 0);
      step();
      drive(1, 0, 2'b00, 32'h40, 0);
      exp_stall = 1; nxt_req = 1; nxt_we = 0; nxt_addr = 32'h40; nxt_be = 4'hF; nxt_wdata = 0;
      step();
      drive(1, 0, 2'b00, 32'h40, 0);
      exp_stall = 1;
      step();
      drive(1, 0, 2'b00, 32'h40, 0);
      exp_stall = 1;
      Rst = 1;
      model_clear();
      step();
      mem_ack = 1;
      mem_rdata = 32'h12345678;
      cmp("rst_req", 32'(mem_req), 0);
      cmp("rst_ldata", LoadData_out, 0);
      step();
      cmp("rst_late_ack_lvalid", 32'(LoadValid_out), 0);
      for (int i = 0; i < 200; i++) begin
         int kind;
         bit rd, wr;
         kind = int'($urandom_range(0, 9));
         rd = (kind < 5) || kind == 9;
         wr = (kind >= 5 && kind < 8) || kind == 9;
         op(rd, wr, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5)));
      end
      step();
      chk_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
